// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit add/subtract processed DIGIT bits per clock through a DIGIT-bit ripple chain.
// Latency: done pulses in the cycle after accepting edge + N (N = WIDTH/DIGIT).
// Backpressure: start is taken only in IDLE/DONE; starts during RUN are dropped, not queued.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    generate
        if ((WIDTH % DIGIT) != 0 || N < 1) begin : g_bad_cfg
            $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   sum;
    logic             last_dig;

    // Operands are shifted right each RUN edge, so the current digit always sits at the bottom.
    assign a_dig    = a_q[DIGIT-1:0];
    assign b_dig    = b_q[DIGIT-1:0];
    assign sum      = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    assign last_dig = (cnt_q == CW'(N - 1));

    // Next-state, datapath and result update for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    // Subtract inverts b only; cin passes straight through, so sub=1
                    // yields a-b-(~cin) and cin behaves as an active-low borrow-in.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = cin;
                    cnt_d   = '0;
                    s_d     = '0;
                    cout_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = sum[DIGIT];
                for (int i = 0; i < N; i++) begin
                    if (cnt_q == CW'(i)) begin
                        s_d[i*DIGIT +: DIGIT] = sum[DIGIT-1:0];
                    end
                end
                cnt_d = cnt_q + CW'(1);
                if (last_dig) begin
                    cnt_d   = '0;
                    cout_d  = sum[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
                    // Carry into the MSB recovered from the MSB sum bit and its operands.
                    ovf_d   = sum[DIGIT] ^ (a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ sum[DIGIT-1]);
`endif
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three configurations (8/1, 8/4, 4/2) checked against an arithmetic model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at that point too.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       sub, cin;
    logic [7:0] a, b;
    logic       start0, start1, start2;
    logic       busy0, done0, cout0, ovf0;
    logic       busy1, done1, cout1, ovf1;
    logic       busy2, done2, cout2, ovf2;
    logic [7:0] s0, s1;
    logic [3:0] s2;

    int total = 0;
    int bad   = 0;

`ifdef SERIAL_ADDER_OVF_EN
    localparam logic [9:0] RMASK = 10'h3FF;
`else
    localparam logic [9:0] RMASK = 10'h1FF;
    assign ovf0 = 1'b0;
    assign ovf1 = 1'b0;
    assign ovf2 = 1'b0;
`endif

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (
        .clk(clk), .rst(rst), .start(start0), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy0), .done(done0), .s(s0), .cout(cout0)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf0)
`endif
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy1), .done(done1), .s(s1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf1)
`endif
    );

    serial_adder #(.WIDTH(4), .DIGIT(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub), .a(a[3:0]), .b(b[3:0]), .cin(cin),
        .busy(busy2), .done(done2), .s(s2), .cout(cout2)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic logic [9:0] model(input int w, input logic [7:0] aa, input logic [7:0] bb,
                                         input logic cc, input logic ss);
        int m, half, ai, bi, sa, sb, r, sr;
        logic co, ov;
        logic [7:0] sv;
        m    = (1 << w) - 1;
        half = 1 << (w - 1);
        ai   = int'(aa) & m;
        bi   = int'(bb) & m;
        sa   = (ai >= half) ? ai - (1 << w) : ai;
        sb   = (bi >= half) ? bi - (1 << w) : bi;
        if (ss) begin
            r  = ai - bi - (cc ? 0 : 1);
            sr = sa - sb - (cc ? 0 : 1);
            co = (r >= 0);
        end else begin
            r  = ai + bi + (cc ? 1 : 0);
            sr = sa + sb + (cc ? 1 : 0);
            co = (r > m);
        end
        ov = (sr < -half) || (sr > half - 1);
        r  = r & m;
        sv = r[7:0];
        return {ov, co, sv} & RMASK;
    endfunction

    function automatic logic done_of(input int u);
        case (u)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic busy_of(input int u);
        case (u)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic [9:0] res_of(input int u);
        case (u)
            0:       return {ovf0, cout0, s0} & RMASK;
            1:       return {ovf1, cout1, s1} & RMASK;
            default: return {ovf2, cout2, 4'h0, s2} & RMASK;
        endcase
    endfunction

    task automatic set_start(input int u, input logic v);
        case (u)
            0:       start0 = v;
            1:       start1 = v;
            default: start2 = v;
        endcase
    endtask

    // One operation; operands and start are scrambled during RUN, which must be ignored.
    task automatic run_op(input int u, input logic [7:0] aa, input logic [7:0] bb,
                          input logic cc, input logic ss, output logic [9:0] res, output int lat);
        a = aa; b = bb; cin = cc; sub = ss;
        set_start(u, 1'b1);
        @(posedge clk); #1;
        set_start(u, 1'b0);
        lat = 0;
        while (!done_of(u) && lat < 64) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            sub = 1'($urandom);
            cin = 1'($urandom);
            set_start(u, 1'($urandom));
            @(posedge clk); #1;
            lat++;
        end
        set_start(u, 1'b0);
        res = res_of(u);
    endtask

    task automatic check_op(input string tag, input int u, input int w, input int n,
                            input logic [7:0] aa, input logic [7:0] bb, input logic cc, input logic ss);
        logic [9:0] res;
        int lat;
        run_op(u, aa, bb, cc, ss, res, lat);
        check({tag, "_res"}, 32'(res), 32'(model(w, aa, bb, cc, ss)));
        check({tag, "_lat"}, lat, n);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] res;
        logic [9:0] exp_r;
        logic [7:0] ra, rb;
        logic       rc, rs;
        int lat, ndone, first, prev, cyc, guard;

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_s", s0, 8'h00);
        check("rst_cout", cout0, 1'b0);
        check("rst_busy1", busy1, 1'b0);
        check("rst_s2", s2, 4'h0);
        rst = 1'b0;

        // Directed: 5A+3C on 8/1.
        run_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, res, lat);
        check("t1_lat", lat, 8);
        check("t1_s", res[7:0], 8'h96);
        check("t1_cout", res[8], 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
        check("t1_ovf", res[9], 1'b1);
`endif
        check("t1_busy_in_done", busy0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_s", s0, 8'h96);
        check("hold_done", done0, 1'b0);
        check("hold_busy", busy0, 1'b0);

        // Directed: FF+01+1 on 8/4.
        run_op(1, 8'hFF, 8'h01, 1'b1, 1'b0, res, lat);
        check("t2_lat", lat, 2);
        check("t2_s", res[7:0], 8'h01);
        check("t2_cout", res[8], 1'b1);

        // Directed subtraction with cin=1.
        run_op(0, 8'h10, 8'h20, 1'b1, 1'b1, res, lat);
        check("t3a_s", res[7:0], 8'hF0);
        check("t3a_cout", res[8], 1'b0);
        run_op(0, 8'h20, 8'h10, 1'b1, 1'b1, res, lat);
        check("t3b_s", res[7:0], 8'h10);
        check("t3b_cout", res[8], 1'b1);

        // start held high throughout: one done every N+1 cycles, no idle bubble.
        @(posedge clk); #1;
        a = 8'hC3; b = 8'h5D; cin = 1'b1; sub = 1'b0;
        exp_r = model(8, 8'hC3, 8'h5D, 1'b1, 1'b0);
        start0 = 1'b1;
        ndone = 0; first = -1; prev = -1;
        for (cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            if (prev >= 0 && cyc == prev + 1) check("b2b_busy", busy0, 1'b1);
            if (done0) begin
                check("b2b_res", 32'(res_of(0)), 32'(exp_r));
                if (prev >= 0) check("b2b_gap", cyc - prev, 9);
                else first = cyc;
                prev = cyc;
                ndone++;
            end
        end
        start0 = 1'b0;
        check("b2b_first", first, 8);
        check("b2b_count", ndone, 3);
        guard = 0;
        while (!done0 && guard < 20) begin @(posedge clk); #1; guard++; end
        check("b2b_drain", done0, 1'b1);

        // Reset in the middle of RUN with counter at 3.
        a = 8'h5A; b = 8'h3C; cin = 1'b0; sub = 1'b0;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy_before", busy0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_busy", busy0, 1'b0);
        check("mid_rst_done", done0, 1'b0);
        check("mid_rst_s", s0, 8'h00);
        check("mid_rst_cout", cout0, 1'b0);
        check_op("mid_fresh", 0, 8, 8, 8'h7F, 8'h01, 1'b0, 1'b0);

        // Exhaustive 4/2 over every operand, carry-in and mode.
        for (int i = 0; i < 1024; i++) begin
            ra = 8'(i & 15);
            rb = 8'((i >> 4) & 15);
            rc = 1'((i >> 8) & 1);
            rs = 1'((i >> 9) & 1);
            check_op("exh42", 2, 4, 2, ra, rb, rc, rs);
        end

        // Random operations on the two 8-bit configurations.
        for (int i = 0; i < 150; i++) begin
            check_op("rnd81", 0, 8, 8, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            check_op("rnd84", 1, 8, 2, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        check("final_busy", busy_of(1), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
